// File: rtl/async_fifo_pkg.sv
// Shared pointer helpers for the async FIFO read and write sides.
package async_fifo_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 4;
    // Pointers carry one extra wrap bit above the address.
    localparam int unsigned DEFAULT_PTR_W      = DEFAULT_ADDR_WIDTH + 1;
    // Helpers work on a 32-bit container; callers zero-extend and truncate with casts.
    localparam int unsigned MAX_PTR_W          = 32;

    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // XOR prefix from the MSB down; leading zeros from zero-extension are harmless.
    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] gray);
        logic [MAX_PTR_W-1:0] bin;
        bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter of configurable width.
module gray2bin #(
    parameter int unsigned WIDTH = async_fifo_pkg::DEFAULT_PTR_W
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Width is bounded by the package helper container.
    assign bin_o = WIDTH'(async_fifo_pkg::gray2bin(32'(gray_i)));

endmodule

// File: rtl/rd_ptr_empty.sv
// Read-side pointer, RAM address and empty/level status for the async FIFO (rd_clk domain).
module rd_ptr_empty
    import async_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH          = DEFAULT_ADDR_WIDTH,
    parameter int unsigned ALMOST_EMPTY_THRESH = 2
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH:0]   wr_ptr_gray_sync,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic                  rd_empty,
    output logic                  rd_almost_empty,
    output logic [ADDR_WIDTH:0]   rd_level
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0] rd_bin_q, rd_bin_d;
    logic [PTR_W-1:0] rd_gray_q, rd_gray_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic             empty_q, empty_d;
    logic             almost_q, almost_d;
    logic [PTR_W-1:0] wr_bin_sync;
    logic             rd_inc;

    gray2bin #(
        .WIDTH (PTR_W)
    ) u_wr_gray2bin (
        .gray_i (wr_ptr_gray_sync),
        .bin_o  (wr_bin_sync)
    );

    // Next pointer and status, all computed against the post-read pointer so that
    // draining the last word raises empty on the same edge the pointer advances.
    always_comb begin
        rd_inc    = rd_en & ~empty_q;
        rd_bin_d  = rd_bin_q + PTR_W'(rd_inc);
        rd_gray_d = PTR_W'(bin2gray(32'(rd_bin_d)));
        level_d   = wr_bin_sync - rd_bin_d;
        empty_d   = (rd_gray_d == wr_ptr_gray_sync);
        almost_d  = (32'(level_d) <= ALMOST_EMPTY_THRESH);
    end

    // State registers with synchronous reset overriding any read.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            rd_bin_q  <= '0;
            rd_gray_q <= '0;
            level_q   <= '0;
            empty_q   <= 1'b1;
            almost_q  <= 1'b1;
        end else begin
            rd_bin_q  <= rd_bin_d;
            rd_gray_q <= rd_gray_d;
            level_q   <= level_d;
            empty_q   <= empty_d;
            almost_q  <= almost_d;
        end
    end

    assign rd_addr         = rd_bin_q[ADDR_WIDTH-1:0];
    assign rd_ptr_gray     = rd_gray_q;
    assign rd_empty        = empty_q;
    assign rd_almost_empty = almost_q;
    assign rd_level        = level_q;

endmodule
